// File: rtl/fetch_seq.sv
// fetch_seq: PC sequencer in front of an instruction memory. After reset it
// spends one cycle in BOOT loading RESET_VECTOR. In FETCH it requests the
// instruction at pc_q, and in STALL it waits for downstream. Branch and trap
// redirects are held until the next PC update. A fetch that gets no ack for
// ACK_TIMEOUT cycles traps to TRAP_VECTOR and sets a sticky error flag.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pc_q           current PC register value
//   next_pc        value to load into the PC register
//   pc_we          PC register write enable (one-cycle pulse per update)
//   imem_req       fetch request (FETCH only)
//   imem_addr      fetch address (pc_q in FETCH, else 0)
//   imem_ack       fetch complete
//   instr_valid    fetched instruction accepted
//   stall          downstream cannot advance the PC
//   branch_valid   redirect pulse; branch_target is the redirect address
//   trap_req       trap pulse
//   timeout_err    sticky fetch-timeout flag, cleared only by reset
module fetch_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_q,
    output logic [31:0] next_pc,
    output logic        pc_we,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    output logic        timeout_err
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_trap_q, pend_trap_d;
    logic        pend_br_q, pend_br_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        timeout_err_q, timeout_err_d;

    logic [31:0] pc_inc;
    logic        trap_now, br_now;
    logic [31:0] tgt_now, redirect_pc;
    logic        capture, consume;

    assign pc_inc      = pc_q + 32'd4;
    assign timeout_err = timeout_err_q;

    // Redirect view including requests arriving this cycle. A trap (pending or
    // new) masks every branch; a new branch replaces an older pending one.
    always_comb begin
        trap_now    = pend_trap_q | trap_req;
        br_now      = ~trap_now & (branch_valid | pend_br_q);
        tgt_now     = branch_valid ? branch_target : pend_tgt_q;
        redirect_pc = trap_now ? TRAP_VECTOR : (br_now ? tgt_now : pc_inc);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        pc_we         = 1'b0;
        next_pc       = pc_inc;
        imem_req      = 1'b0;
        imem_addr     = 32'h0000_0000;
        instr_valid   = 1'b0;
        capture       = 1'b0;
        consume       = 1'b0;

        unique case (state_q)
            StBoot: begin
                // Gated by rst_n so pc_we stays low while reset is held.
                pc_we   = rst_n;
                next_pc = RESET_VECTOR;
                cnt_d   = 8'd0;
                state_d = StFetch;
            end
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                capture   = 1'b1;
                if (imem_ack) begin
                    instr_valid = 1'b1;
                    cnt_d       = 8'd0;
                    if (!stall) begin
                        pc_we   = 1'b1;
                        next_pc = redirect_pc;
                        consume = 1'b1;
                    end else begin
                        state_d = StStall;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    pc_we         = 1'b1;
                    next_pc       = TRAP_VECTOR;
                    timeout_err_d = 1'b1;
                    cnt_d         = 8'd0;
                    consume       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStall: begin
                cnt_d   = 8'd0;
                capture = 1'b1;
                if (!stall) begin
                    pc_we   = 1'b1;
                    next_pc = redirect_pc;
                    consume = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pend_trap_d = pend_trap_q;
        pend_br_d   = pend_br_q;
        pend_tgt_d  = pend_tgt_q;
        if (consume) begin
            pend_trap_d = 1'b0;
            pend_br_d   = 1'b0;
        end else if (capture) begin
            pend_trap_d = trap_now;
            pend_br_d   = br_now;
            pend_tgt_d  = br_now ? tgt_now : pend_tgt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            cnt_q         <= 8'd0;
            pend_trap_q   <= 1'b0;
            pend_br_q     <= 1'b0;
            pend_tgt_q    <= 32'h0000_0000;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_trap_q   <= pend_trap_d;
            pend_br_q     <= pend_br_d;
            pend_tgt_q    <= pend_tgt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        pc_we;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        trap_req;
    logic        timeout_err;

    logic [31:0] exp_q[$];
    logic [31:0] want;
    int          n_cmp;
    int          n_err;

    fetch_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_q         (pc_q),
        .next_pc      (next_pc),
        .pc_we        (pc_we),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .trap_req     (trap_req),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks enter and leave positioned 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        imem_ack     = 1'b0;
        branch_valid = 1'b0;
        trap_req     = 1'b0;
    endtask

    // One acked fetch with stall=0; expected next_pc popped from the scoreboard.
    task automatic ack_cycle(input string name, input logic [31:0] pc);
        pc_q     = pc;
        imem_ack = 1'b1;
        stall    = 1'b0;
        @(negedge clk);
        want = exp_q.pop_front();
        n_cmp++;
        if (pc_we !== 1'b1 || next_pc !== want || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: pc_we=%b next_pc=%h instr_valid=%b, required 1 %h 1",
                     name, pc_we, next_pc, instr_valid, want);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_q = 32'h0; imem_ack = 1'b0; stall = 1'b0;
        branch_valid = 1'b0; branch_target = 32'h0; trap_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pc_we !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            next_pc !== 32'h0 || imem_addr !== 32'h0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: we=%b req=%b iv=%b npc=%h addr=%h terr=%b, required 0 0 0 0 0 0",
                     pc_we, imem_req, instr_valid, next_pc, imem_addr, timeout_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        want = exp_q.pop_front();
        n_cmp++;
        if (pc_we !== 1'b1 || next_pc !== want || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL boot: pc_we=%b next_pc=%h req=%b, required 1 %h 0",
                     pc_we, next_pc, imem_req, want);
        end
        step();
    endtask

    task automatic test_boot_fetch();
        pc_q = 32'h0000_0040;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0040 || pc_we !== 1'b0 ||
            instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_after_boot: req=%b addr=%h we=%b iv=%b, required 1 00000040 0 0",
                     imem_req, imem_addr, pc_we, instr_valid);
        end
        step();
    endtask

    task automatic test_sequential();
        exp_q.push_back(32'h0000_0014);
        ack_cycle("seq_0x10", 32'h0000_0010);
        exp_q.push_back(32'h0000_1004);
        ack_cycle("seq_back_to_back", 32'h0000_1000);
    endtask

    task automatic test_branch();
        pc_q = 32'h0000_0010;
        branch_valid = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clk);
        n_cmp++;
        if (pc_we !== 1'b0) begin
            n_err++;
            $display("FAIL branch_no_update: pc_we=%b, required 0", pc_we);
        end
        step();
        step();
        exp_q.push_back(32'h0000_0200);
        ack_cycle("branch_taken", 32'h0000_0010);
        exp_q.push_back(32'h0000_0014);
        ack_cycle("branch_cleared", 32'h0000_0010);
        // Later branch replaces earlier pending branch.
        branch_valid = 1'b1; branch_target = 32'h0000_0300;
        step();
        branch_valid = 1'b1; branch_target = 32'h0000_0400;
        step();
        exp_q.push_back(32'h0000_0400);
        ack_cycle("branch_replaced", 32'h0000_0010);
    endtask

    task automatic test_trap();
        branch_valid = 1'b1; branch_target = 32'h0000_0200; trap_req = 1'b1;
        exp_q.push_back(32'h0000_0080);
        ack_cycle("trap_same_cycle_branch", 32'h0000_0010);
        // Pending trap must not be displaced by a later branch.
        trap_req = 1'b1;
        step();
        branch_valid = 1'b1; branch_target = 32'h0000_0500;
        step();
        exp_q.push_back(32'h0000_0080);
        ack_cycle("trap_beats_later_branch", 32'h0000_0010);
        // Trap arriving on the ack cycle overrides a pending branch.
        branch_valid = 1'b1; branch_target = 32'h0000_0600;
        step();
        trap_req = 1'b1;
        exp_q.push_back(32'h0000_0080);
        ack_cycle("trap_over_pending_branch", 32'h0000_0020);
    endtask

    task automatic test_stall();
        pc_q = 32'h0000_0020; imem_ack = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pc_we !== 1'b0 || instr_valid !== (i == 0) || imem_req !== (i == 0)) begin
                n_err++;
                $display("FAIL stall_cycle%0d: we=%b iv=%b req=%b, required 0 %b %b",
                         i, pc_we, instr_valid, imem_req, i == 0, i == 0);
            end
            step();
            imem_ack = 1'b1; // ignored in STALL
        end
        stall = 1'b0;
        exp_q.push_back(32'h0000_0024);
        @(negedge clk);
        want = exp_q.pop_front();
        n_cmp++;
        if (pc_we !== 1'b1 || next_pc !== want || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: we=%b npc=%h req=%b iv=%b, required 1 %h 0 0",
                     pc_we, next_pc, imem_req, instr_valid, want);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL stall_back_to_fetch: req=%b addr=%h, required 1 00000020",
                     imem_req, imem_addr);
        end
        step();
        imem_ack = 1'b1;
        exp_q.push_back(32'h0000_0024);
        ack_cycle("after_stall_seq", 32'h0000_0020);
    endtask

    task automatic test_wrap();
        exp_q.push_back(32'h0000_0000);
        ack_cycle("wrap", 32'hFFFF_FFFC);
    endtask

    task automatic test_timeout();
        pc_q = 32'h0000_0030;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                branch_valid = 1'b1; branch_target = 32'h0000_0700;
            end
            if (i == 16) exp_q.push_back(32'h0000_0080);
            @(negedge clk);
            n_cmp++;
            if (i < 16) begin
                if (pc_we !== 1'b0 || timeout_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_wait%0d: we=%b terr=%b, required 0 0",
                             i, pc_we, timeout_err);
                end
            end else begin
                want = exp_q.pop_front();
                if (pc_we !== 1'b1 || next_pc !== want) begin
                    n_err++;
                    $display("FAIL timeout_trap: we=%b npc=%h, required 1 %h", pc_we, next_pc, want);
                end
            end
            step();
        end
        // Timeout discards the pending branch.
        exp_q.push_back(32'h0000_0034);
        ack_cycle("timeout_cleared_branch", 32'h0000_0030);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (timeout_err !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_sticky%0d: terr=%b, required 1", i, timeout_err);
            end
            step();
        end
    endtask

    task automatic test_reset_in_stall();
        pc_q = 32'h0000_0050; imem_ack = 1'b1; stall = 1'b1;
        step();
        branch_valid = 1'b1; branch_target = 32'h0000_0900;
        step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc_we !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            next_pc !== 32'h0 || imem_addr !== 32'h0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: we=%b req=%b iv=%b npc=%h addr=%h terr=%b, required 0 0 0 0 0 0",
                     pc_we, imem_req, instr_valid, next_pc, imem_addr, timeout_err);
        end
        step();
        step();
        rst_n = 1'b1; stall = 1'b0;
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        want = exp_q.pop_front();
        n_cmp++;
        if (pc_we !== 1'b1 || next_pc !== want || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reboot: we=%b npc=%h req=%b, required 1 %h 0",
                     pc_we, next_pc, imem_req, want);
        end
        step();
        exp_q.push_back(32'h0000_0054);
        ack_cycle("reset_dropped_branch", 32'h0000_0050);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_boot_fetch();
        test_sequential();
        test_branch();
        test_trap();
        test_stall();
        test_wrap();
        test_timeout();
        test_reset_in_stall();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
